// File: rtl/proc_run_ctrl_pkg.sv
// Shared definitions for the processor run controller: FSM state encoding and
// a parameter range check used at elaboration.
package proc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam int unsigned MAX_CORES = 16;

  // The watchdog limit must be nonzero and representable in the cycle counter.
  function automatic bit params_ok(input int unsigned num_cores,
                                   input int unsigned rst_cycles,
                                   input int unsigned cnt_w,
                                   input int unsigned timeout_cycles);
    return (num_cores >= 1) && (num_cores <= MAX_CORES) &&
           (rst_cycles >= 1) && (cnt_w >= 1) && (timeout_cycles != 0) &&
           ((cnt_w >= 64) || (64'(timeout_cycles) < (64'd1 << cnt_w)));
  endfunction

endpackage

// File: rtl/proc_halt_log.sv
// Per-core first-halt capture: each slice records the RUN cycle number at which
// its core was first seen halted. Only present when PROC_RUN_HALT_LOG_EN is defined.
`ifdef PROC_RUN_HALT_LOG_EN
module proc_halt_log #(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic [NUM_CORES-1:0]       capture_i,
  input  logic [CNT_W-1:0]           count_i,
  output logic [NUM_CORES*CNT_W-1:0] halt_cycle_o
);

  logic [NUM_CORES*CNT_W-1:0] halt_cycle_q, halt_cycle_d;

  always_comb begin
    halt_cycle_d = halt_cycle_q;
    if (clear_i) begin
      halt_cycle_d = '1;
    end else begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (capture_i[i]) halt_cycle_d[i*CNT_W +: CNT_W] = count_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) halt_cycle_q <= '1;
    else         halt_cycle_q <= halt_cycle_d;
  end

  assign halt_cycle_o = halt_cycle_q;

endmodule
`endif

// File: rtl/proc_run_ctrl.sv
// Run controller: holds cores in reset, releases the enabled ones, counts RUN cycles
// and flags done/timeout. PROC_RUN_HALT_LOG_EN adds the per-core halt_cycle_o log.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 1,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [NUM_CORES-1:0]       core_en_i,
  input  logic [NUM_CORES-1:0]       core_halt_i,
  output logic [NUM_CORES-1:0]       core_rst_o,
  output logic                       run_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [CNT_W-1:0]           cycle_count_o,
`ifdef PROC_RUN_HALT_LOG_EN
  output logic [NUM_CORES*CNT_W-1:0] halt_cycle_o,
`endif
  output logic [NUM_CORES-1:0]       halted_mask_o
);

  if (!params_ok(NUM_CORES, RST_CYCLES, CNT_W, TIMEOUT_CYCLES)) begin : g_bad_params
    $error("proc_run_ctrl: parameter out of range");
  end

  localparam int unsigned      HOLD_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_CORES-1:0] en_q, en_d;
  logic [NUM_CORES-1:0] halted_mask_q, halted_mask_d;
  logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 all_halt;

  // Halts arriving this cycle count toward completion, so DONE is not a cycle late.
  assign all_halt = (((halted_mask_q | core_halt_i) & en_q) == en_q);

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    en_d          = en_q;
    halted_mask_d = halted_mask_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    timeout_d     = timeout_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_i) begin
          state_d       = ST_HOLD;
          en_d          = core_en_i;
          hold_cnt_d    = HOLD_INIT;
          halted_mask_d = '0;
          cycle_count_d = '0;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      ST_HOLD: begin
        if (abort_i)                 state_d = ST_IDLE;
        else if (hold_cnt_q == '0)   state_d = ST_RUN;
        else                         hold_cnt_d = hold_cnt_q - 1'b1;
      end
      ST_RUN: begin
        cycle_count_d = cycle_count_q + 1'b1;
        halted_mask_d = halted_mask_q | (core_halt_i & en_q);
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (all_halt) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    core_rst_d = (state_d == ST_RUN) ? ~en_d : '1;
    run_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      en_q          <= '0;
      halted_mask_q <= '0;
      cycle_count_q <= '0;
      core_rst_q    <= '1;
      run_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      en_q          <= en_d;
      halted_mask_q <= halted_mask_d;
      cycle_count_q <= cycle_count_d;
      core_rst_q    <= core_rst_d;
      run_q         <= run_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign core_rst_o    = core_rst_q;
  assign run_o         = run_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign cycle_count_o = cycle_count_q;
  assign halted_mask_o = halted_mask_q;

`ifdef PROC_RUN_HALT_LOG_EN
  logic                 start_acc;
  logic [NUM_CORES-1:0] halt_new;
  logic [CNT_W-1:0]     run_cycle_num;

  // The log records the 1-based RUN cycle number, i.e. the count after this cycle.
  assign start_acc     = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                     (state_q == ST_TIMEOUT));
  assign halt_new      = core_halt_i & en_q & ~halted_mask_q & {NUM_CORES{state_q == ST_RUN}};
  assign run_cycle_num = cycle_count_q + 1'b1;

  proc_halt_log #(
    .NUM_CORES (NUM_CORES),
    .CNT_W     (CNT_W)
  ) u_halt_log (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (start_acc),
    .capture_i    (halt_new),
    .count_i      (run_cycle_num),
    .halt_cycle_o (halt_cycle_o)
  );
`endif

endmodule
